// File: rtl/flag_update_ctrl.sv
// flag_update_ctrl: sequences flag register writes, interrupt flag stack and branch condition evaluation
module flag_update_ctrl #(
    parameter int STACK_DEPTH = 4,
    parameter int PTR_W       = 3
) (
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic       alu_valid,
    output logic       alu_ready,
    input  logic [1:0] alu_class,
    input  logic [3:0] alu_flags,
    input  logic       clr_req,
    input  logic       irq_save,
    input  logic       irq_restore,
    input  logic [3:0] Flag_reg,
    output logic [2:0] FLAG_CTRL,
    output logic [3:0] Flag_in,
    output logic       CLEAR_FLG,
    input  logic       cond_valid,
    input  logic [3:0] cond_code,
    output logic       cond_ready,
    output logic       cond_done,
    output logic       cond_true,
    output logic       stack_err
);
    typedef enum logic {IDLE, RESTORE} state_t;
    state_t state, state_nx;
    logic [PTR_W-1:0] ptr, ptr_nx, top;
    logic [3:0] stack [1<<PTR_W];
    logic [2:0] ctrl_nx;
    logic [3:0] in_nx;
    logic [7:0] tbl;
    logic clr_nx, err_nx, push, prev_wr, cond_res, n, z, c, v;
    assign top = ptr - 1'b1;
    assign {n, z, c, v} = Flag_reg;
    // codes come in complementary pairs: even code picks a base term, odd code inverts it
    assign tbl = {1'b1, ~z & (n ~^ v), n ~^ v, c & ~z, v, n, c, z};
    assign cond_res = tbl[cond_code[3:1]] ^ cond_code[0];
    assign cond_ready = !(state == RESTORE || (alu_ready && alu_valid && alu_class != 2'd0) ||
                          FLAG_CTRL != 3'b000 || CLEAR_FLG || prev_wr);
    always_comb begin
        state_nx  = state;
        alu_ready = 1'b0;
        ctrl_nx   = 3'b000;
        in_nx     = 4'b0000;
        clr_nx    = 1'b0;
        ptr_nx    = ptr;
        push      = 1'b0;
        err_nx    = stack_err;
        if (state == RESTORE) begin
            state_nx = IDLE;
            ctrl_nx  = 3'b111;
            in_nx    = stack[top];
            ptr_nx   = top;
        end else if (clr_req) begin
            clr_nx = 1'b1;
        end else if (irq_restore) begin
            if (ptr == '0) err_nx = 1'b1;
            else state_nx = RESTORE;
        end else begin
            alu_ready = 1'b1;
            if (alu_valid) begin
                ctrl_nx = {alu_class == 2'd3, alu_class[1], alu_class != 2'd0};
                in_nx   = alu_flags;
            end
            if (irq_save) begin
                if (ptr == PTR_W'(STACK_DEPTH)) err_nx = 1'b1;
                else begin
                    push   = 1'b1;
                    ptr_nx = ptr + 1'b1;
                end
            end
        end
    end
    always_ff @(posedge Clock) begin
        if (!Reset_n) state <= IDLE;
        else state <= state_nx;
    end
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            ptr       <= '0;
            stack_err <= 1'b0;
            FLAG_CTRL <= 3'b000;
            Flag_in   <= 4'b0000;
            CLEAR_FLG <= 1'b0;
            prev_wr   <= 1'b0;
            cond_done <= 1'b0;
            cond_true <= 1'b0;
        end else begin
            ptr       <= ptr_nx;
            stack_err <= err_nx;
            FLAG_CTRL <= ctrl_nx;
            Flag_in   <= in_nx;
            CLEAR_FLG <= clr_nx;
            prev_wr   <= (FLAG_CTRL != 3'b000) || CLEAR_FLG;
            cond_done <= cond_valid && cond_ready;
            if (cond_valid && cond_ready) cond_true <= cond_res;
        end
    end
    // stack contents need no reset: the pointer alone defines what is valid
    always_ff @(posedge Clock) begin
        if (push) stack[ptr] <= Flag_reg;
    end
endmodule

// File: tb/tb_flag_update_ctrl.sv
// tb_flag_update_ctrl: directed self-checking bench with a behavioural flag register model
module tb_flag_update_ctrl;
    logic       Clock = 1'b0;
    logic       Reset_n = 1'b0;
    logic       alu_valid = 1'b0;
    logic       alu_ready;
    logic [1:0] alu_class = 2'd0;
    logic [3:0] alu_flags = 4'h0;
    logic       clr_req = 1'b0;
    logic       irq_save = 1'b0;
    logic       irq_restore = 1'b0;
    logic [3:0] flag_reg;
    logic [2:0] FLAG_CTRL;
    logic [3:0] Flag_in;
    logic       CLEAR_FLG;
    logic       cond_valid = 1'b0;
    logic [3:0] cond_code = 4'h0;
    logic       cond_ready;
    logic       cond_done;
    logic       cond_true;
    logic       stack_err;
    logic       load_en = 1'b0;
    logic [3:0] load_val = 4'h0;
    int n_chk = 0;
    int n_pass = 0;

    flag_update_ctrl dut (
        .Clock(Clock), .Reset_n(Reset_n), .alu_valid(alu_valid), .alu_ready(alu_ready),
        .alu_class(alu_class), .alu_flags(alu_flags), .clr_req(clr_req), .irq_save(irq_save),
        .irq_restore(irq_restore), .Flag_reg(flag_reg), .FLAG_CTRL(FLAG_CTRL), .Flag_in(Flag_in),
        .CLEAR_FLG(CLEAR_FLG), .cond_valid(cond_valid), .cond_code(cond_code),
        .cond_ready(cond_ready), .cond_done(cond_done), .cond_true(cond_true), .stack_err(stack_err)
    );

    always #5 Clock = ~Clock;

    // the flag register the controller drives
    always @(posedge Clock) begin
        if (!Reset_n) flag_reg <= 4'h0;
        else if (load_en) flag_reg <= load_val;
        else if (CLEAR_FLG) flag_reg <= 4'h0;
        else begin
            if (FLAG_CTRL[0]) flag_reg[3:2] <= Flag_in[3:2];
            if (FLAG_CTRL[1]) flag_reg[1] <= Flag_in[1];
            if (FLAG_CTRL[2]) flag_reg[0] <= Flag_in[0];
        end
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic load(input logic [3:0] v);
        load_en = 1'b1;
        load_val = v;
        tick();
        load_en = 1'b0;
    endtask

    task automatic query(input string tag, input logic [3:0] code, input logic exp);
        cond_valid = 1'b1;
        cond_code = code;
        #1;
        for (int i = 0; i < 8 && !cond_ready; i++) tick();
        check({tag, "_rdy"}, 8'(cond_ready), 8'd1);
        tick();
        cond_valid = 1'b0;
        check({tag, "_done"}, 8'(cond_done), 8'd1);
        check(tag, 8'(cond_true), 8'(exp));
    endtask

    logic [3:0] vals [4] = '{4'h1, 4'h2, 4'h4, 4'h8};
    logic [3:0] codes_a [9] = '{4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd4, 4'd6, 4'd3};
    logic       exp_a [9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [3:0] codes_b [8] = '{4'd0, 4'd8, 4'd9, 4'd10, 4'd12, 4'd13, 4'd2, 4'd5};
    logic       exp_b [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

    initial begin
        tick();
        tick();
        check("rst_ctrl", 8'(FLAG_CTRL), 8'h0);
        check("rst_in", 8'(Flag_in), 8'h0);
        check("rst_clr", 8'(CLEAR_FLG), 8'h0);
        check("rst_err", 8'(stack_err), 8'h0);
        check("rst_done", 8'(cond_done), 8'h0);
        check("rst_true", 8'(cond_true), 8'h0);
        Reset_n = 1'b1;
        #1;
        check("rst_alu_rdy", 8'(alu_ready), 8'h1);
        check("rst_cond_rdy", 8'(cond_ready), 8'h1);

        // arith update plus same-cycle query: interlock for three cycles
        alu_valid = 1'b1; alu_class = 2'd3; alu_flags = 4'b1011;
        cond_valid = 1'b1; cond_code = 4'd1;
        #1;
        check("ar_alu_rdy", 8'(alu_ready), 8'h1);
        check("ilk_c0", 8'(cond_ready), 8'h0);
        tick();
        alu_valid = 1'b0;
        #1;
        check("ar_ctrl", 8'(FLAG_CTRL), 8'h7);
        check("ar_in", 8'(Flag_in), 8'hb);
        check("ilk_c1", 8'(cond_ready), 8'h0);
        tick();
        check("ar_reg", 8'(flag_reg), 8'hb);
        check("ilk_c2", 8'(cond_ready), 8'h0);
        tick();
        check("ilk_c3", 8'(cond_ready), 8'h1);
        tick();
        cond_valid = 1'b0;
        check("ne_done", 8'(cond_done), 8'h1);
        check("ne_true", 8'(cond_true), 8'h1);
        tick();
        check("done_pulse", 8'(cond_done), 8'h0);
        check("true_hold", 8'(cond_true), 8'h1);

        // logic class writes only N,Z
        load(4'h0);
        alu_valid = 1'b1; alu_class = 2'd1; alu_flags = 4'b0111;
        tick();
        alu_valid = 1'b0;
        check("lg_ctrl", 8'(FLAG_CTRL), 8'h1);
        tick();
        check("lg_reg", 8'(flag_reg), 8'h4);
        query("lg_cs", 4'd2, 1'b0);
        query("lg_eq", 4'd0, 1'b1);

        // shift class writes N,Z,C
        load(4'h0);
        alu_valid = 1'b1; alu_class = 2'd2; alu_flags = 4'b1111;
        tick();
        alu_valid = 1'b0;
        check("sh_ctrl", 8'(FLAG_CTRL), 8'h3);
        tick();
        check("sh_reg", 8'(flag_reg), 8'he);
        query("sh_vc", 4'd7, 1'b1);

        // save with same-cycle update, then restore
        load(4'hc);
        irq_save = 1'b1;
        alu_valid = 1'b1; alu_class = 2'd3; alu_flags = 4'b0011;
        tick();
        irq_save = 1'b0; alu_valid = 1'b0;
        check("sv_ctrl", 8'(FLAG_CTRL), 8'h7);
        check("sv_in", 8'(Flag_in), 8'h3);
        tick();
        check("sv_reg", 8'(flag_reg), 8'h3);
        irq_restore = 1'b1;
        alu_valid = 1'b1; alu_flags = 4'hf;
        #1;
        check("rs_rdy0", 8'(alu_ready), 8'h0);
        tick();
        irq_restore = 1'b0;
        #1;
        check("rs_rdy1", 8'(alu_ready), 8'h0);
        check("rs_ctrl0", 8'(FLAG_CTRL), 8'h0);
        alu_valid = 1'b0;
        tick();
        check("rs_ctrl", 8'(FLAG_CTRL), 8'h7);
        check("rs_in", 8'(Flag_in), 8'hc);
        tick();
        check("rs_reg", 8'(flag_reg), 8'hc);
        check("rs_alu_rdy", 8'(alu_ready), 8'h1);

        // fill the stack from empty, then overflow
        for (int i = 0; i < 4; i++) begin
            load(vals[i]);
            irq_save = 1'b1;
            tick();
            irq_save = 1'b0;
            check($sformatf("push%0d_err", i), 8'(stack_err), 8'h0);
        end
        load(4'hf);
        irq_save = 1'b1;
        tick();
        irq_save = 1'b0;
        check("ovf_err", 8'(stack_err), 8'h1);
        irq_restore = 1'b1;
        tick();
        irq_restore = 1'b0;
        tick();
        check("ovf_pop_in", 8'(Flag_in), 8'h8);
        check("ovf_pop_ctrl", 8'(FLAG_CTRL), 8'h7);
        tick();
        check("ovf_pop_reg", 8'(flag_reg), 8'h8);
        check("err_sticky", 8'(stack_err), 8'h1);

        // underflow after reset
        Reset_n = 1'b0;
        tick();
        Reset_n = 1'b1;
        check("rst2_err", 8'(stack_err), 8'h0);
        irq_restore = 1'b1;
        tick();
        irq_restore = 1'b0;
        check("unf_err", 8'(stack_err), 8'h1);
        check("unf_ctrl0", 8'(FLAG_CTRL), 8'h0);
        tick();
        check("unf_ctrl1", 8'(FLAG_CTRL), 8'h0);

        // reset during RESTORE abandons the write and empties the stack
        Reset_n = 1'b0;
        tick();
        Reset_n = 1'b1;
        load(4'h5);
        irq_save = 1'b1;
        tick();
        irq_save = 1'b0;
        irq_restore = 1'b1;
        tick();
        irq_restore = 1'b0;
        Reset_n = 1'b0;
        tick();
        Reset_n = 1'b1;
        check("mid_ctrl", 8'(FLAG_CTRL), 8'h0);
        check("mid_in", 8'(Flag_in), 8'h0);
        irq_restore = 1'b1;
        tick();
        irq_restore = 1'b0;
        check("mid_empty_err", 8'(stack_err), 8'h1);
        tick();
        check("mid_empty_ctrl", 8'(FLAG_CTRL), 8'h0);

        // clear beats a same-cycle ALU update
        load(4'hf);
        clr_req = 1'b1;
        alu_valid = 1'b1; alu_class = 2'd3; alu_flags = 4'b1010;
        #1;
        check("clr_alu_rdy", 8'(alu_ready), 8'h0);
        tick();
        clr_req = 1'b0; alu_valid = 1'b0;
        check("clr_strobe", 8'(CLEAR_FLG), 8'h1);
        check("clr_ctrl", 8'(FLAG_CTRL), 8'h0);
        tick();
        check("clr_pulse", 8'(CLEAR_FLG), 8'h0);
        check("clr_reg", 8'(flag_reg), 8'h0);
        query("al", 4'd14, 1'b1);
        query("nv", 4'd15, 1'b0);

        // condition table sweeps on two flag patterns
        load(4'b1001);
        for (int i = 0; i < 9; i++) query($sformatf("cc9_%0d", codes_a[i]), codes_a[i], exp_a[i]);
        load(4'b0110);
        for (int i = 0; i < 8; i++) query($sformatf("cc6_%0d", codes_b[i]), codes_b[i], exp_b[i]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/flag_update_ctrl.md
Name: flag_update_ctrl

Overview:
Controller that sequences the 4-bit condition (flag) register. It turns ALU flag-update requests, clear requests and interrupt save/restore events into the register's per-group write enables, clear strobe and data. It keeps a small shadow stack of flag values for interrupt entry and return. It also evaluates branch condition codes against the live flags, with a hazard interlock against in-flight updates.

Parameters:
STACK_DEPTH, 4, number of saved flag words (1..8)
PTR_W, 3, stack pointer width; must satisfy 2^PTR_W >= STACK_DEPTH+1

Ports:
Clock  in  1  single system clock; all state updates on rising edge
Reset_n  in  1  synchronous, active-low reset
alu_valid  in  1  ALU result flags available this cycle
alu_ready  out  1  update accepted when alu_valid & alu_ready
alu_class  in  2  0 none, 1 logic (NZ), 2 shift (NZC), 3 arith (NZCV)
alu_flags  in  4  {N,Z,C,V} computed by ALU
clr_req  in  1  clear all flags
irq_save  in  1  push current flags (interrupt entry)
irq_restore  in  1  pop and reload flags (interrupt return)
Flag_reg  in  4  current register contents {N,Z,C,V}
FLAG_CTRL  out  3  write enables: [0]=N,Z  [1]=C  [2]=V
Flag_in  out  4  data to register {N,Z,C,V}
CLEAR_FLG  out  1  active-high clear strobe to register
cond_valid  in  1  branch condition query
cond_code  in  4  condition code
cond_ready  out  1  query accepted when cond_valid & cond_ready
cond_done  out  1  one-cycle pulse, result valid
cond_true  out  1  condition result, held until next cond_done
stack_err  out  1  sticky overflow/underflow flag

Behaviour:
- Reset (Reset_n=0 at edge): FSM=IDLE, stack ptr=0, stack_err=0, cond_done=0, cond_true=0. Registered outputs FLAG_CTRL=000, CLEAR_FLG=0, Flag_in=0000.
- FLAG_CTRL, Flag_in and CLEAR_FLG are registered: a request accepted at edge k drives the register during cycle k+1; the register updates at edge k+2.
- FSM states: IDLE, RESTORE. IDLE -> RESTORE on accepted irq_restore with stack non-empty. RESTORE lasts one cycle: drive Flag_in=stack[ptr-1], FLAG_CTRL=111, decrement ptr, then return to IDLE.
- Per-cycle priority in IDLE: clr_req > irq_restore > ALU update. irq_save is independent of the ALU update.
  - clr_req: CLEAR_FLG=1 next cycle, FLAG_CTRL=000. The same-cycle ALU update is dropped (alu_ready=0).
  - irq_restore: alu_ready=0 in the request cycle and in the RESTORE cycle.
- ALU update enables by class: logic -> 001, shift -> 011, arith -> 111, none -> 000 (no write). Flag_in=alu_flags.
- alu_ready=1 in IDLE unless clr_req or irq_restore is asserted.
- irq_save pushes the current Flag_reg, which is the pre-update value even if an ALU update is accepted the same cycle. Push while ptr==STACK_DEPTH is dropped and sets stack_err. irq_save together with irq_restore or clr_req is ignored (save dropped, no error).
- irq_restore with ptr==0 sets stack_err; no write, stays IDLE.
- stack_err is sticky until reset.
- Hazard interlock: cond_ready=0 while any flag write is pending, i.e. an update accepted this cycle, or FLAG_CTRL!=000 or CLEAR_FLG=1 in this or the previous cycle, or FSM=RESTORE. Otherwise cond_ready=1.
- An accepted query registers its result: cond_done=1 and cond_true are valid the cycle after acceptance.
- Condition codes: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !C|Z; 10 GE N==V; 11 LT N!=V; 12 GT !Z&(N==V); 13 LE Z|(N!=V); 14 AL 1; 15 NV 0.
- Reset mid-RESTORE: the pending write is abandoned, outputs return to reset values, and the stack is emptied.

Test Plan:
- Reset, then arith update with alu_flags=1011 -> FLAG_CTRL=111, Flag_in=1011 next cycle; Flag_reg=1011 after edge; cond NE -> cond_true=0? No: Z=0, so NE true -> cond_true=1.
- Flag_reg=0000; logic update with flags=0111 -> FLAG_CTRL=001 only; resulting Flag_reg=0100; query CS -> cond_true=0; query EQ -> cond_true=1.
- Interlock: accept an ALU update and assert cond_valid the same cycle -> cond_ready=0 for 3 cycles; when granted, the result reflects the new flags.
- Save Flag_reg=1100, arith update to 0011, restore -> alu_ready=0 for 2 cycles, FLAG_CTRL=111, Flag_in=1100; Flag_reg=1100; ptr back to 0.
- STACK_DEPTH=4: 5 saves -> stack_err=1 on the 5th and ptr stays 4; reset, then restore on empty stack -> stack_err=1, FLAG_CTRL stays 000.
- clr_req with alu_valid in the same cycle -> alu_ready=0, CLEAR_FLG pulses 1 cycle, Flag_reg=0000; query AL -> 1; query NV -> 0.
